// File: rtl/pixel_stream_pkg.sv
// ----------------------------------------------------------------------------
// pixel_stream_pkg
// Shared types and helpers for pixel_stream_ctl.
//   state_t    : controller FSM state encoding (IDLE, READ, SEND, LATCH)
//   word_fields_t / split_word : split a frame-RAM word {next_addr, pixel}
//                into its link and pixel fields for given field widths.
// ----------------------------------------------------------------------------
package pixel_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_t;

    // Widest RAM word the helper handles (ADDR_W <= 32, PIX_W <= 32).
    localparam int unsigned WORD_MAX_W = 64;

    typedef struct packed {
        logic [31:0] link;
        logic [31:0] pix;
    } word_fields_t;

    // Pixel occupies the low pix_w bits, the link the addr_w bits above it.
    function automatic word_fields_t split_word(input logic [WORD_MAX_W-1:0] word,
                                                input int unsigned          pix_w,
                                                input int unsigned          addr_w);
        word_fields_t           f;
        logic [WORD_MAX_W-1:0]  pix_mask;
        logic [WORD_MAX_W-1:0]  link_mask;
        pix_mask  = ~({WORD_MAX_W{1'b1}} << pix_w);
        link_mask = ~({WORD_MAX_W{1'b1}} << addr_w);
        f.pix     = 32'(word & pix_mask);
        f.link    = 32'((word >> pix_w) & link_mask);
        return f;
    endfunction

endpackage

// File: rtl/bit_shifter.sv
// ----------------------------------------------------------------------------
// bit_shifter
// Holds one pixel and presents it MSB-first, one bit per accepted handshake.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   load_i         : capture pix_i and point at bit PIX_W-1
//   pix_i          : pixel word to serialise
//   vld_i, rdy_i   : bit handshake; index advances on vld_i & rdy_i
//   bit_o          : currently selected pixel bit
//   last_o         : index is 0 (LSB is being presented)
// Valid/ready: a bit is consumed only on a cycle where vld_i and rdy_i are
// both high; otherwise the index and the held pixel stay put, so bit_o is
// stable for as long as the consumer stalls.
// ----------------------------------------------------------------------------
module bit_shifter #(
    parameter int PIX_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [PIX_W-1:0] pix_i,
    input  logic             vld_i,
    input  logic             rdy_i,
    output logic             bit_o,
    output logic             last_o
);

    localparam int IDX_W = $clog2(PIX_W);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PIX_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [PIX_W-1:0] pix_q;
    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pix_q <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            pix_q <= pix_i;
            idx_q <= IDX_MSB;
        end else if (vld_i && rdy_i && (idx_q != '0)) begin
            idx_q <= idx_q - IDX_ONE;
        end
    end

    assign bit_o  = pix_q[idx_q];
    assign last_o = (idx_q == '0);

endmodule

// File: rtl/pixel_stream_ctl.sv
// ----------------------------------------------------------------------------
// pixel_stream_ctl
// Walks a linked list of {next_addr, pixel} words in frame RAM and streams
// each pixel MSB-first to the bit-code generator, then enforces a latch gap.
//   clk_i, rst_n_i  : clock, synchronous active-low reset
//   frame_start_i   : 1-cycle pulse, start a frame at start_addr_i
//   start_addr_i    : first word address (link value 0 ends a list, but
//                     address 0 is a legal first word)
//   ram_rd_addr_o   : RAM read address
//   ram_rd_data_i   : RAM word {next_addr, pixel}, RD_LAT cycles after addr
//   bit_vld_o/bit_data_o/bit_rdy_i : bit stream handshake
//   busy_o          : high from accepted start to end of latch gap
//   frame_done_o    : 1-cycle pulse when the latch gap completes
//   err_o           : (PIXEL_STREAM_CTL_LOOP_GUARD_EN only) 1-cycle pulse
//                     when a frame is dropped for exceeding MAX_PIX words
// Valid/ready: a bit transfers on a cycle with bit_vld_o & bit_rdy_i; while
// bit_vld_o is high and bit_rdy_i low, bit_vld_o and bit_data_o hold.
// Starts arriving while busy land in a one-deep pending slot (last wins) and
// are served directly out of the final latch cycle.
// Optional feature macro: PIXEL_STREAM_CTL_LOOP_GUARD_EN.
// ----------------------------------------------------------------------------
module pixel_stream_ctl
    import pixel_stream_pkg::*;
#(
    parameter int PIX_W     = 24,
    parameter int ADDR_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int LATCH_CYC = 4000
`ifdef PIXEL_STREAM_CTL_LOOP_GUARD_EN
    ,
    parameter int MAX_PIX   = 2**ADDR_W
`endif
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    frame_start_i,
    input  logic [ADDR_W-1:0]       start_addr_i,
    output logic [ADDR_W-1:0]       ram_rd_addr_o,
    input  logic [ADDR_W+PIX_W-1:0] ram_rd_data_i,
    output logic                    bit_vld_o,
    output logic                    bit_data_o,
    input  logic                    bit_rdy_i,
    output logic                    busy_o,
    output logic                    frame_done_o
`ifdef PIXEL_STREAM_CTL_LOOP_GUARD_EN
    ,
    output logic                    err_o
`endif
);

    localparam int LAT_W = $clog2(LATCH_CYC + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYC - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    // READ spans RD_LAT+1 cycles: address out, RAM register(s), capture.
    localparam logic [1:0]       RD_LAST  = 2'(RD_LAT);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   link_q;
    logic [1:0]          rd_cnt_q;
    logic [LAT_W-1:0]    latch_cnt_q;
    logic                pend_vld_q;
    logic [ADDR_W-1:0]   pend_addr_q;
    logic                done_q;

    logic                load_pix;
    logic                enter_read;
    logic [ADDR_W-1:0]   read_addr;
    logic                latch_end;
    logic                sh_bit;
    logic                sh_last;

    word_fields_t        fields;
    logic                unused_fields;

    assign fields        = split_word(WORD_MAX_W'(ram_rd_data_i), PIX_W, ADDR_W);
    assign unused_fields = ^fields;

`ifdef PIXEL_STREAM_CTL_LOOP_GUARD_EN
    localparam int PC_W = $clog2(MAX_PIX + 1);
    localparam logic [PC_W-1:0] PIX_MAX_C = PC_W'(MAX_PIX);
    localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);

    logic [PC_W-1:0] pix_cnt_q;
    logic            err_q;
    logic            guard_trip;
    logic            new_frame;

    // Entering READ from IDLE or LATCH is a frame start; from SEND it is a link.
    assign new_frame = enter_read && (state_q != SEND);
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state and control ----------------
    always_comb begin
        state_d    = state_q;
        load_pix   = 1'b0;
        enter_read = 1'b0;
        read_addr  = addr_q;
        latch_end  = 1'b0;
`ifdef PIXEL_STREAM_CTL_LOOP_GUARD_EN
        guard_trip = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    state_d    = READ;
                    enter_read = 1'b1;
                    read_addr  = start_addr_i;
                end
            end
            READ: begin
                if (rd_cnt_q == RD_LAST) begin
                    state_d  = SEND;
                    load_pix = 1'b1;
                end
            end
            SEND: begin
                if (bit_rdy_i && sh_last) begin
                    if (link_q == '0) begin
                        state_d = LATCH;
                    end
`ifdef PIXEL_STREAM_CTL_LOOP_GUARD_EN
                    else if (pix_cnt_q == PIX_MAX_C) begin
                        state_d    = LATCH;
                        guard_trip = 1'b1;
                    end
`endif
                    else begin
                        state_d    = READ;
                        enter_read = 1'b1;
                        read_addr  = link_q;
                    end
                end
            end
            LATCH: begin
                if (latch_cnt_q == LAT_LAST) begin
                    latch_end = 1'b1;
                    // A start in this very cycle beats an older pending one.
                    if (frame_start_i || pend_vld_q) begin
                        state_d    = READ;
                        enter_read = 1'b1;
                        read_addr  = frame_start_i ? start_addr_i : pend_addr_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            addr_q      <= '0;
            link_q      <= '0;
            rd_cnt_q    <= '0;
            latch_cnt_q <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= latch_end;
            rd_cnt_q    <= (state_q == READ)  ? rd_cnt_q + 2'd1       : 2'd0;
            latch_cnt_q <= (state_q == LATCH) ? latch_cnt_q + LAT_ONE : '0;
            if (enter_read) begin
                addr_q <= read_addr;
            end
            if (load_pix) begin
                link_q <= fields.link[ADDR_W-1:0];
            end
            if (latch_end) begin
                pend_vld_q <= 1'b0;
            end else if (frame_start_i && (state_q != IDLE)) begin
                pend_vld_q  <= 1'b1;
                pend_addr_q <= start_addr_i;
            end
        end
    end

`ifdef PIXEL_STREAM_CTL_LOOP_GUARD_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pix_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= guard_trip;
            if (new_frame) begin
                pix_cnt_q <= PC_ONE;
            end else if (enter_read) begin
                pix_cnt_q <= pix_cnt_q + PC_ONE;
            end
        end
    end

    assign err_o = err_q;
`endif

    bit_shifter #(
        .PIX_W (PIX_W)
    ) u_shifter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (load_pix),
        .pix_i   (fields.pix[PIX_W-1:0]),
        .vld_i   (bit_vld_o),
        .rdy_i   (bit_rdy_i),
        .bit_o   (sh_bit),
        .last_o  (sh_last)
    );

    assign bit_vld_o     = (state_q == SEND);
    assign bit_data_o    = bit_vld_o & sh_bit;
    assign busy_o        = (state_q != IDLE);
    assign frame_done_o  = done_q;
    assign ram_rd_addr_o = addr_q;

endmodule

// File: doc/pixel_stream_ctl.md
Name: pixel_stream_ctl

Overview:
- Parametrised successor of the NeoPixel waveform controller. It walks a linked list of pixel words in frame RAM and serialises each pixel MSB-first to the bit-code generator over a valid/ready handshake.
- Generalised in pixel width (RGB/RGBW), address width and RAM read latency.
- Adds an explicit start address, a programmable latch (reset-code) gap, a one-deep pending-start queue and busy/done status.
- Sits between the frame RAM write side and the per-channel bit-code generator.

Parameters:
- PIX_W, 24, pixel bits per word (24 = GRB, 32 = GRBW); valid range 8..32.
- ADDR_W, 8, RAM address width; link field width.
- RD_LAT, 1, RAM read latency in cycles; valid values 1 or 2.
- LATCH_CYC, 4000, idle cycles enforced after the last bit before the next frame may start; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, synchronous, active-low
- frame_start_i  in  1  single-cycle pulse: begin frame at start_addr_i
- start_addr_i  in  ADDR_W  first word address, sampled with frame_start_i
- ram_rd_addr_o  out  ADDR_W  RAM read address
- ram_rd_data_i  in  ADDR_W+PIX_W  word = {next_addr, pixel}; next_addr == 0 terminates the list
- bit_vld_o  out  1  bit_data_o valid
- bit_data_o  out  1  current bit
- bit_rdy_i  in  1  downstream accepts the bit when bit_vld_o & bit_rdy_i
- busy_o  out  1  high from the accepted start through the end of LATCH
- frame_done_o  out  1  one-cycle pulse when LATCH completes

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low (rst_n_i sampled on the clk_i rising edge).
- Reset values: every output is 0, state is IDLE, the pending flag is cleared. Reset asserted mid-frame aborts immediately with no further bits; bit_vld_o drops on the same clock edge.
- States:
  - IDLE: on frame_start_i, load ram_rd_addr_o <= start_addr_i, set busy_o, go to READ.
  - READ: wait RD_LAT cycles, then capture pixel into the shift register and next_addr into the link register, load bit index = PIX_W-1, go to SEND.
  - SEND: bit_vld_o = 1, bit_data_o = pixel[index]. On a handshake:
    - index > 0: decrement index.
    - index == 0 and next_addr != 0: set ram_rd_addr_o <= next_addr, go to READ.
    - index == 0 and next_addr == 0: go to LATCH.
  - LATCH: bit_vld_o = 0; count LATCH_CYC cycles. On the final count, pulse frame_done_o. If a start is pending, take the pending address and go to READ with busy_o held high; otherwise clear busy_o and go to IDLE.
- Handshake: while bit_vld_o & !bit_rdy_i, bit_vld_o and bit_data_o are held stable. bit_vld_o is 0 in READ, so there is an RD_LAT+1 cycle bubble between pixels. This is acceptable because the bit-code generator is far slower.
- frame_start_i while busy_o (any non-IDLE state): store start_addr_i in a one-deep pending slot. A later start before service overwrites the slot (last wins). frame_start_i and the final LATCH cycle in the same cycle counts as pending and is served immediately.
- Self-link (next_addr == current address) is not detected in the base build; the list repeats forever.
- Width rules:
  - bit index is $clog2(PIX_W) bits.
  - latch counter is $clog2(LATCH_CYC+1) bits.
  - a start address of 0 is legal as a first word; only a link value of 0 terminates.

Optional Feature:
- Macro: PIXEL_STREAM_CTL_LOOP_GUARD_EN.
- Defined:
  - Adds parameter MAX_PIX (default 2**ADDR_W) and output err_o (reset 0).
  - A pixel counter increments at each READ entry. If a READ is entered when the count already equals MAX_PIX, the block drops the frame: no further bits, err_o pulses 1 cycle, and it goes to LATCH (frame_done_o still pulses).
  - Counter clears at each frame start.
- Undefined: no counter, no err_o port, unbounded lists.

Decomposition:
- Package pixel_stream_pkg:
  - state_t enum {IDLE, READ, SEND, LATCH} (2 bits);
  - function to split a RAM word into link and pixel fields given ADDR_W/PIX_W.
- Sub-module bit_shifter: pixel load, indexed MSB-first bit select, index counter, last-bit flag, all under valid/ready. The FSM, latch counter and pending slot stay in the top.

Test Plan:
- PIX_W=24, RD_LAT=1, start=0x10, word@0x10={0x00,0xA5_0F_3C}, bit_rdy_i=1 -> 24 bits 101001010000111100111100, then LATCH_CYC idle cycles, frame_done_o one pulse, busy_o falls the same cycle.
- Three-word list 0x02->0x07->0x05->0 with random bit_rdy_i stalls -> 72 bits in list order, no bit dropped or duplicated, bit_data_o stable while stalled, ram_rd_addr_o sequence 0x02,0x07,0x05.
- PIX_W=32, RD_LAT=2, pixel 0x8000_0001 -> first bit 1, 30 zeros, last bit 1; exactly 3 vld-low cycles between pixels.
- frame_start_i twice mid-frame (addr 0x20, then 0x30) -> after LATCH the next frame starts at 0x30 with busy_o continuously high; frame_done_o pulses once per frame.
- rst_n_i low for 1 cycle during bit 12 -> next edge: all outputs 0, IDLE; no bits until a new frame_start_i.
- With PIXEL_STREAM_CTL_LOOP_GUARD_EN, MAX_PIX=4, self-linked word at 0x03 -> exactly 96 bits, err_o one pulse, LATCH then frame_done_o.
